fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter pBITS, default 8: data width of the paired register file; unused internally and kept for instantiation symmetry.
REQ-002 SHALL have parameter pWIDHT, default 2: address width; depth D = 2**pWIDHT.
REQ-003 SHALL have parameter pAF_LEVEL, default 3: almost-full threshold in entries, legal range 1..D.
REQ-004 SHALL have port iclk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port irst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port iwr, input, 1: push request.
REQ-007 SHALL have port ird, input, 1: pop request; head data is read combinationally from the register file at or_addr.
REQ-008 SHALL have port iclr_err, input, 1: clears the sticky error flags.
REQ-009 SHALL have port owr_en, output, 1: write enable to the register file.
REQ-010 SHALL have port ow_addr, output, pWIDHT: register-file write address (write pointer).
REQ-011 SHALL have port or_addr, output, pWIDHT: register-file read address (read pointer).
REQ-012 SHALL have port ofull, output, 1: FIFO holds D entries.
REQ-013 SHALL have port oempty, output, 1: FIFO holds 0 entries.
REQ-014 SHALL have port oalmost_full, output, 1: count >= pAF_LEVEL.
REQ-015 SHALL have port ocount, output, pWIDHT+1: current occupancy, 0..D.
REQ-016 SHALL have port oovf, output, 1: sticky overflow, set when a push is rejected.
REQ-017 SHALL have port ounf, output, 1: sticky underflow, set when a pop is rejected.

Function
REQ-018 SHALL hold wr_ptr, rd_ptr (pWIDHT bits each, wrapping modulo D) and a count register; ow_addr = wr_ptr and or_addr = rd_ptr, both combinational from the registers.
REQ-019 SHALL accept a push when iwr=1 and (ofull=0 or an accepted pop occurs in the same cycle).
REQ-020 SHALL accept a pop when ird=1 and oempty=0.
REQ-021 SHALL drive owr_en = accepted push, combinationally in the same cycle, and force owr_en=0 while irst=1.
REQ-022 SHALL, on an accepted push, increment wr_ptr at the next edge; D-1 wraps to 0.
REQ-023 SHALL, on an accepted pop, increment rd_ptr at the next edge; D-1 wraps to 0.
REQ-024 SHALL update count at the next edge by: push only +1; pop only -1; both or neither, unchanged.
REQ-025 SHALL, when push and pop are both accepted while full, keep count=D with ofull=1; the head entry is read before the edge and overwritten at the edge.
REQ-026 SHALL, when iwr=1 and ird=1 while empty, accept the push only, reject the pop, set ounf, and move to count=1.
REQ-027 SHALL make ofull, oempty and oalmost_full registered, decoded from the next count value, so they are valid in the same cycle ocount changes; there are no extra flag-latency cycles.
REQ-028 SHALL set oovf on iwr=1 with the push rejected, and set ounf on ird=1 with the pop rejected; both flags remain set until cleared.
REQ-029 SHALL clear oovf and ounf on iclr_err=1; a new error event in the same cycle wins and leaves the flag set.
REQ-030 SHALL leave pointers, count and flags unchanged on any rejected request.
REQ-031 SHALL be pure synchronous logic, with no state machine beyond the pointers and count; total latency from an accepted push to oempty=0 is 1 cycle.

Reset
REQ-032 SHALL, on irst=1 at a rising edge, set wr_ptr=0, rd_ptr=0, ocount=0, oempty=1, ofull=0, oalmost_full=0, oovf=0, ounf=0.
REQ-033 SHALL give irst priority over iwr, ird and iclr_err; a reset mid-operation discards all contents without generating error flags.

Verification (pWIDHT=2, pAF_LEVEL=3)
REQ-034 SHALL cover reset and fill: reset, then 4 single pushes -> ow_addr 0,1,2,3; ocount 1,2,3,4; oalmost_full rises with ocount=3; ofull=1 after the 4th push; oempty=0 after the 1st push.
REQ-035 SHALL cover overflow: when full, iwr=1 with ird=0 -> owr_en=0, ocount stays 4, oovf=1 next cycle; then iclr_err=1 -> oovf=0.
REQ-036 SHALL cover underflow on empty: ird=1 alone -> ounf=1, rd_ptr stays 0; iwr=1 and ird=1 together -> ocount=1, ounf stays set.
REQ-037 SHALL cover wrap-around: push 4 entries, pop 4, then push 2 -> ow_addr wraps from 3 to 0 then 1; pops return data in order; or_addr wraps from 3 to 0.
REQ-038 SHALL cover simultaneous push and pop when full: ocount stays 4, both pointers advance by 1, owr_en=1, and the popped value equals the oldest entry.
REQ-039 SHALL cover reset mid-operation: at ocount=2, irst=1 with iwr=1 -> owr_en=0, and next cycle ocount=0, oempty=1, with no error flags set.

Source files
------------

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
//
// Pointer and occupancy controller for a FIFO built around an external
// register file of 2**pWIDHT entries. This block holds no data. It decides
// whether each push or pop is taken, steers the register-file addresses, and
// reports occupancy and error status.
//
// Parameters
//   pBITS      data width of the paired register file. The controller does not
//              use it; it is kept so both halves take the same parameter list.
//   pWIDHT     address width; depth D = 2**pWIDHT
//   pAF_LEVEL  almost-full threshold in entries, legal range 1..D
//
// Ports
//   iclk          clock; all state changes on the rising edge
//   irst          synchronous, active-high reset; overrides every request
//   iwr           push request
//   ird           pop request; head data is read combinationally at or_addr
//   iclr_err      clears the sticky error flags
//   owr_en        register-file write enable (accepted push, same cycle)
//   ow_addr       register-file write address (write pointer)
//   or_addr       register-file read address (read pointer)
//   ofull         FIFO holds D entries
//   oempty        FIFO holds 0 entries
//   oalmost_full  occupancy >= pAF_LEVEL
//   ocount        occupancy, 0..D
//   oovf          sticky overflow: a push was rejected
//   ounf          sticky underflow: a pop was rejected
//
// Handshake: a request is a single-cycle level on iwr/ird. There is no
// ready/valid pair. A request is either accepted or rejected in the cycle it
// is presented, and it is never held over to a later cycle. A push is
// accepted when the FIFO is not full, or when a pop is accepted in the same
// cycle. A pop is accepted when the FIFO is not empty. A rejected request
// leaves pointers and occupancy untouched and sets the matching sticky flag.
//
// The controller has no FSM. Its only state is the two pointers, the count
// and the registered flags.
// ---------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int pBITS     = 8,
  parameter int pWIDHT    = 2,
  parameter int pAF_LEVEL = 3
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              iwr,
  input  logic              ird,
  input  logic              iclr_err,
  output logic              owr_en,
  output logic [pWIDHT-1:0] ow_addr,
  output logic [pWIDHT-1:0] or_addr,
  output logic              ofull,
  output logic              oempty,
  output logic              oalmost_full,
  output logic [pWIDHT:0]   ocount,
  output logic              oovf,
  output logic              ounf
);

  // The count is one bit wider than the pointers so that it can hold D.
  localparam logic [pWIDHT:0]   DEPTH     = {1'b1, {pWIDHT{1'b0}}};
  localparam logic [pWIDHT:0]   AF_LEVEL  = (pWIDHT+1)'(pAF_LEVEL);
  localparam logic [pWIDHT:0]   CNT_ONE   = (pWIDHT+1)'(1);
  localparam logic [pWIDHT-1:0] PTR_ONE   = pWIDHT'(1);

  // Catch illegal configurations at elaboration time, not in silicon.
  if (pBITS < 1 || pWIDHT < 1 || pAF_LEVEL < 1 || pAF_LEVEL > (1 << pWIDHT))
  begin : g_param_check
    $error("fifo_ctrl: illegal parameters (pBITS>=1, pWIDHT>=1, 1<=pAF_LEVEL<=D)");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [pWIDHT-1:0] wr_ptr;
  logic [pWIDHT-1:0] rd_ptr;
  logic [pWIDHT:0]   count;
  logic              full_q;
  logic              empty_q;
  logic              af_q;
  logic              ovf_q;
  logic              unf_q;

  // -------------------------------------------------------------------------
  // Request qualification and next-state decode
  // -------------------------------------------------------------------------
  logic            pop_ok;
  logic            push_ok;
  logic            ovf_evt;
  logic            unf_evt;
  logic [pWIDHT:0] count_nxt;
  logic            full_nxt;
  logic            empty_nxt;
  logic            af_nxt;

  always_comb begin
    pop_ok  = ird & ~empty_q;
    // When the FIFO is full, a push is still taken if the head leaves in the
    // same cycle. The head is read before the edge and its slot is
    // overwritten at the edge.
    push_ok = iwr & (~full_q | pop_ok);
    ovf_evt = iwr & ~push_ok;
    unf_evt = ird & ~pop_ok;

    count_nxt = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase

    // The flags are decoded from the next count and registered alongside it,
    // so they change in the same cycle as ocount.
    full_nxt  = (count_nxt == DEPTH);
    empty_nxt = (count_nxt == '0);
    af_nxt    = (count_nxt >= AF_LEVEL);
  end

  // -------------------------------------------------------------------------
  // Sequential update
  // -------------------------------------------------------------------------
  always_ff @(posedge iclk) begin
    if (irst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      // The pointers are exactly pWIDHT bits wide, so the increment wraps
      // from D-1 to 0 without an explicit compare.
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_nxt;
      full_q  <= full_nxt;
      empty_q <= empty_nxt;
      af_q    <= af_nxt;
      // On a clear, an error event in the same cycle still leaves its flag set.
      if (iclr_err) begin
        ovf_q <= ovf_evt;
        unf_q <= unf_evt;
      end else begin
        ovf_q <= ovf_q | ovf_evt;
        unf_q <= unf_q | unf_evt;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Reset must block the write strobe. Otherwise a push in the reset cycle
  // would corrupt a slot of the register file.
  assign owr_en       = push_ok & ~irst;
  assign ow_addr      = wr_ptr;
  assign or_addr      = rd_ptr;
  assign ocount       = count;
  assign ofull        = full_q;
  assign oempty       = empty_q;
  assign oalmost_full = af_q;
  assign oovf         = ovf_q;
  assign ounf         = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl
//
// Directed bench for fifo_ctrl with pWIDHT=2 (D=4) and pAF_LEVEL=3.
//
// Each row of stimulus is driven 1 ns after a rising edge and held for the
// whole cycle. The row's hand-computed expectation is packed into exp_q. The
// monitor samples the DUT on the following falling edge, pops that entry and
// compares.
//
// An expectation covers three things:
//   - the registered outputs as they stand after the previous edge;
//   - owr_en for the inputs of this row;
//   - optionally, the head data a pop would return.
// A small register-file model captures data on owr_en, so FIFO ordering can
// be checked end to end.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;

  localparam int BITS  = 8;
  localparam int WIDHT = 2;
  localparam int AF    = 3;
  // Packed expectation layout, most significant field first:
  //   owr_en, ow_addr[2], or_addr[2], ofull, oempty, oalmost_full,
  //   ocount[3], oovf, ounf, dchk, data[8]
  localparam int W     = 22;

  // Clock/reset block
  logic iclk = 1'b0;
  logic irst;
  always #5 iclk = ~iclk;

  logic             iwr, ird, iclr_err;
  logic             owr_en;
  logic [WIDHT-1:0] ow_addr, or_addr;
  logic             ofull, oempty, oalmost_full;
  logic [WIDHT:0]   ocount;
  logic             oovf, ounf;
  logic [BITS-1:0]  wdata;

  fifo_ctrl #(
    .pBITS     (BITS),
    .pWIDHT    (WIDHT),
    .pAF_LEVEL (AF)
  ) dut (
    .iclk         (iclk),
    .irst         (irst),
    .iwr          (iwr),
    .ird          (ird),
    .iclr_err     (iclr_err),
    .owr_en       (owr_en),
    .ow_addr      (ow_addr),
    .or_addr      (or_addr),
    .ofull        (ofull),
    .oempty       (oempty),
    .oalmost_full (oalmost_full),
    .ocount       (ocount),
    .oovf         (oovf),
    .ounf         (ounf)
  );

  // Paired register file model, written by the DUT's own strobe and address.
  logic [BITS-1:0] mem [4];
  always @(posedge iclk) begin
    if (owr_en) mem[ow_addr] <= wdata;
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  function automatic logic [W-1:0] pack(
    input logic       owr,
    input logic [1:0] wa,
    input logic [1:0] ra,
    input logic       f,
    input logic       e,
    input logic       af,
    input logic [2:0] c,
    input logic       ov,
    input logic       un,
    input logic       dchk,
    input logic [7:0] dat
  );
    return {owr, wa, ra, f, e, af, c, ov, un, dchk, dat};
  endfunction

  // Monitor: compares one expectation per cycle on the falling edge.
  always @(negedge iclk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = pack(owr_en, ow_addr, or_addr, ofull, oempty, oalmost_full,
                   ocount, oovf, ounf, exp_v[8],
                   exp_v[8] ? mem[or_addr] : 8'h00);
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL %s: got owr=%b wa=%0d ra=%0d full=%b empty=%b af=%b cnt=%0d ovf=%b unf=%b data=%h, expected owr=%b wa=%0d ra=%0d full=%b empty=%b af=%b cnt=%0d ovf=%b unf=%b data=%h",
                 nm,
                 act_v[21], act_v[20:19], act_v[18:17], act_v[16], act_v[15], act_v[14],
                 act_v[13:11], act_v[10], act_v[9], act_v[7:0],
                 exp_v[21], exp_v[20:19], exp_v[18:17], exp_v[16], exp_v[15], exp_v[14],
                 exp_v[13:11], exp_v[10], exp_v[9], exp_v[7:0]);
      end
    end
  end

  // Driver: applies one row of inputs and queues its expectation.
  task automatic row(
    input string      nm,
    input logic       rst, wr, rd, clr,
    input logic [7:0] wd,
    input logic       owr,
    input logic [1:0] wa, ra,
    input logic       f, e, af,
    input logic [2:0] c,
    input logic       ov, un, dchk,
    input logic [7:0] dat
  );
    @(posedge iclk);
    #1;
    irst     = rst;
    iwr      = wr;
    ird      = rd;
    iclr_err = clr;
    wdata    = wd;
    exp_q.push_back(pack(owr, wa, ra, f, e, af, c, ov, un, dchk, dat));
    name_q.push_back(nm);
  endtask

  initial begin
    irst = 1'b1; iwr = 1'b0; ird = 1'b0; iclr_err = 1'b0; wdata = '0;
    repeat (2) @(posedge iclk);

    //      name          rst wr rd clr wd     owr wa ra  f  e af c  ov un dchk data
    row("reset_state",    0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    // Fill: ow_addr 0..3, ocount 1..4, almost-full at 3, full at 4
    row("fill_push1",     0, 1, 0, 0, 8'hA1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    row("fill_push2",     0, 1, 0, 0, 8'hA2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    row("fill_push3",     0, 1, 0, 0, 8'hA3, 1, 2, 0, 0, 0, 0, 2, 0, 0, 0, 8'h00);
    row("fill_push4",     0, 1, 0, 0, 8'hA4, 1, 3, 0, 0, 0, 1, 3, 0, 0, 0, 8'h00);
    // Overflow: rejected push, then clear
    row("ovf_push_full",  0, 1, 0, 0, 8'hEE, 0, 0, 0, 1, 0, 1, 4, 0, 0, 0, 8'h00);
    row("ovf_sticky_clr", 0, 0, 0, 1, 8'h00, 0, 0, 0, 1, 0, 1, 4, 1, 0, 0, 8'h00);
    row("ovf_cleared",    0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 4, 0, 0, 0, 8'h00);
    // Push+pop while full: pops oldest, both pointers advance, count stays 4
    row("full_pushpop",   0, 1, 1, 0, 8'hB5, 1, 0, 0, 1, 0, 1, 4, 0, 0, 1, 8'hA1);
    row("full_pp_after",  0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 1, 4, 0, 0, 0, 8'h00);
    // Drain in order: A2 A3 A4 B5
    row("drain_pop1",     0, 0, 1, 0, 8'h00, 0, 1, 1, 1, 0, 1, 4, 0, 0, 1, 8'hA2);
    row("drain_pop2",     0, 0, 1, 0, 8'h00, 0, 1, 2, 0, 0, 1, 3, 0, 0, 1, 8'hA3);
    row("drain_pop3",     0, 0, 1, 0, 8'h00, 0, 1, 3, 0, 0, 0, 2, 0, 0, 1, 8'hA4);
    row("drain_pop4",     0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 8'hB5);
    // Underflow, then push+pop on empty: push only, ounf stays set
    row("unf_pop_empty",  0, 0, 1, 0, 8'h00, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    row("unf_pushpop",    0, 1, 1, 0, 8'hC1, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 8'h00);
    row("unf_pp_after",   0, 0, 0, 0, 8'h00, 0, 2, 1, 0, 0, 0, 1, 0, 1, 0, 8'h00);
    row("unf_clear",      0, 0, 0, 1, 8'h00, 0, 2, 1, 0, 0, 0, 1, 0, 1, 0, 8'h00);
    row("pop_last",       0, 0, 1, 0, 8'h00, 0, 2, 1, 0, 0, 0, 1, 0, 0, 1, 8'hC1);
    // Clear together with a new underflow: the new event wins
    row("clr_vs_unf",     0, 0, 1, 1, 8'h00, 0, 2, 2, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    row("clr_vs_unf_res", 0, 0, 0, 1, 8'h00, 0, 2, 2, 0, 1, 0, 0, 0, 1, 0, 8'h00);
    // Reset while a push is requested: no write strobe
    row("rst_with_push",  1, 1, 0, 0, 8'h77, 0, 2, 2, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    // Underflow from the reset state: rd_ptr stays 0
    row("unf_after_rst",  0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    row("unf_rdptr_0",    0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 8'h00);
    // Wrap-around: push 4, pop 4, push 2
    row("wrap_push0",     0, 1, 0, 0, 8'hD0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    row("wrap_push1",     0, 1, 0, 0, 8'hD1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    row("wrap_push2",     0, 1, 0, 0, 8'hD2, 1, 2, 0, 0, 0, 0, 2, 0, 0, 0, 8'h00);
    row("wrap_push3",     0, 1, 0, 0, 8'hD3, 1, 3, 0, 0, 0, 1, 3, 0, 0, 0, 8'h00);
    row("wrap_pop0",      0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 1, 4, 0, 0, 1, 8'hD0);
    row("wrap_pop1",      0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 3, 0, 0, 1, 8'hD1);
    row("wrap_pop2",      0, 0, 1, 0, 8'h00, 0, 0, 2, 0, 0, 0, 2, 0, 0, 1, 8'hD2);
    row("wrap_pop3",      0, 0, 1, 0, 8'h00, 0, 0, 3, 0, 0, 0, 1, 0, 0, 1, 8'hD3);
    row("wrap_push_e0",   0, 1, 0, 0, 8'hE0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    row("wrap_push_e1",   0, 1, 0, 0, 8'hE1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00);
    // Reset mid-operation at count 2 with a push pending
    row("midrst_push",    1, 1, 0, 0, 8'hFF, 0, 2, 0, 0, 0, 0, 2, 0, 0, 0, 8'h00);
    row("midrst_after",   0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    row("midrst_head",    0, 1, 0, 0, 8'h5A, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    row("midrst_data",    0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 8'h5A);

    // Let the monitor drain the queue, with a bounded wait.
    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge iclk);
        waited++;
      end
      if (exp_q.size() > 0) begin
        n_errors++;
        $display("FAIL drain_timeout: got %0d pending expectations, expected 0",
                 exp_q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
